// File: rtl/apu_ipc_mbox.sv
// Host/APU inter-processor block: soft-IRQ set/clear, one mailbox FIFO per direction,
// FIFO doorbells and APU run control behind a zero-wait AHB-Lite slave.
module apu_ipc_mbox #(
  parameter int NSOFTIRQ = 2,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         ahbls_haddr,
  input  logic [1:0]          ahbls_htrans,
  input  logic                ahbls_hwrite,
  input  logic [2:0]          ahbls_hsize,
  input  logic                ahbls_hready,
  input  logic                ahbls_hmaster,
  output logic                ahbls_hready_resp,
  input  logic [31:0]         ahbls_hwdata,
  output logic [31:0]         ahbls_hrdata,
  output logic                ahbls_hresp,
  output logic                start_apu,
  output logic [NSOFTIRQ-1:0] riscv_softirq,
  output logic [1:0]          fifo_irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [2:0] OFF_SET  = 3'd0;
  localparam logic [2:0] OFF_CLR  = 3'd1;
  localparam logic [2:0] OFF_WR   = 3'd2;
  localparam logic [2:0] OFF_RD   = 3'd3;
  localparam logic [2:0] OFF_ST   = 3'd4;
  localparam logic [2:0] OFF_CTRL = 3'd5;

  // FIFO 0 carries host->APU traffic, FIFO 1 carries APU->host; a requester's outgoing
  // FIFO index equals its hmaster value and its incoming FIFO is the other one.
  logic                dp_valid_r;
  logic [2:0]          dp_off_r;
  logic                dp_write_r;
  logic [2:0]          dp_size_r;
  logic                dp_master_r;

  logic [NSOFTIRQ-1:0] softirq_r;
  logic                run_r;
  logic [1:0]          roe_r;
  logic [1:0]          wof_r;
  logic [PW-1:0]       wptr_r [2];
  logic [PW-1:0]       rptr_r [2];
  logic [31:0]         mem_r  [2][DEPTH];

  logic [PW-1:0]       level_s [2];
  logic [1:0]          empty_s;
  logic [1:0]          full_s;
  logic                data_act_s;
  logic                wr_act_s;
  logic                rd_act_s;
  logic                in_s;
  logic                push_s;
  logic                pop_s;
  logic [8:0]          lvl_s;
  logic [31:0]         hrdata_s;
  logic                unused_s;

  assign data_act_s = dp_valid_r & ahbls_hready;
  assign wr_act_s   = data_act_s & dp_write_r & (dp_size_r == 3'b010);
  assign rd_act_s   = data_act_s & ~dp_write_r;
  assign in_s       = ~dp_master_r;
  assign push_s     = wr_act_s & (dp_off_r == OFF_WR) & ~full_s[dp_master_r];
  assign pop_s      = rd_act_s & (dp_off_r == OFF_RD) & ~empty_s[in_s];
  assign unused_s   = ^{ahbls_haddr[15:5], ahbls_haddr[1:0], ahbls_htrans[0], ahbls_hwdata};

  // FIFO occupancy flags derived from the extra pointer MSB
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      level_s[i] = wptr_r[i] - rptr_r[i];
      empty_s[i] = (wptr_r[i] == rptr_r[i]);
      full_s[i]  = (wptr_r[i][PW-1] != rptr_r[i][PW-1]) &&
                   (wptr_r[i][AW-1:0] == rptr_r[i][AW-1:0]);
    end
  end

  // Read data mux, live only during a read data phase
  always_comb begin
    hrdata_s = 32'h0000_0000;
    lvl_s    = 9'(level_s[in_s]);
    if (rd_act_s) begin
      case (dp_off_r)
        OFF_SET, OFF_CLR: hrdata_s = 32'(softirq_r);
        OFF_RD: begin
          if (!empty_s[in_s]) begin
            hrdata_s = mem_r[in_s][rptr_r[in_s][AW-1:0]];
          end else begin
            hrdata_s = 32'h0000_0000;
          end
        end
        OFF_ST:   hrdata_s = {12'h000, wof_r[dp_master_r], roe_r[dp_master_r],
                              ~full_s[dp_master_r], ~empty_s[in_s], 7'h00, lvl_s};
        OFF_CTRL: hrdata_s = {31'h0000_0000, run_r};
        default:  hrdata_s = 32'h0000_0000;
      endcase
    end else begin
      hrdata_s = 32'h0000_0000;
    end
  end

  // Address-phase capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid_r  <= 1'b0;
      dp_off_r    <= 3'd0;
      dp_write_r  <= 1'b0;
      dp_size_r   <= 3'd0;
      dp_master_r <= 1'b0;
    end else if (ahbls_hready) begin
      dp_valid_r  <= ahbls_htrans[1];
      dp_off_r    <= ahbls_haddr[4:2];
      dp_write_r  <= ahbls_hwrite;
      dp_size_r   <= ahbls_hsize;
      dp_master_r <= ahbls_hmaster;
    end
  end

  // Register and pointer updates at the end of the data phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      softirq_r <= {NSOFTIRQ{1'b0}};
      run_r     <= 1'b0;
      roe_r     <= 2'b00;
      wof_r     <= 2'b00;
      wptr_r[0] <= {PW{1'b0}};
      wptr_r[1] <= {PW{1'b0}};
      rptr_r[0] <= {PW{1'b0}};
      rptr_r[1] <= {PW{1'b0}};
    end else begin
      if (wr_act_s) begin
        case (dp_off_r)
          OFF_SET: softirq_r <= softirq_r | ahbls_hwdata[NSOFTIRQ-1:0];
          OFF_CLR: softirq_r <= softirq_r & ~ahbls_hwdata[NSOFTIRQ-1:0];
          OFF_WR: begin
            if (full_s[dp_master_r]) begin
              wof_r[dp_master_r] <= 1'b1;
            end else begin
              wptr_r[dp_master_r] <= wptr_r[dp_master_r] + PW'(1'b1);
            end
          end
          OFF_ST: begin
            if (ahbls_hwdata[18]) roe_r[dp_master_r] <= 1'b0;
            if (ahbls_hwdata[19]) wof_r[dp_master_r] <= 1'b0;
          end
          OFF_CTRL: begin
            if (!dp_master_r) run_r <= ahbls_hwdata[0];
          end
          default: ;
        endcase
      end
      if (rd_act_s && (dp_off_r == OFF_RD)) begin
        if (pop_s) begin
          rptr_r[in_s] <= rptr_r[in_s] + PW'(1'b1);
        end else begin
          roe_r[dp_master_r] <= 1'b1;
        end
      end
    end
  end

  // Mailbox storage, written only on an accepted push
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[dp_master_r][wptr_r[dp_master_r][AW-1:0]] <= ahbls_hwdata;
    end
  end

  assign ahbls_hready_resp = 1'b1;
  assign ahbls_hresp       = 1'b0;
  assign ahbls_hrdata      = hrdata_s;
  assign start_apu         = run_r;
  assign riscv_softirq     = softirq_r;
  assign fifo_irq          = {~empty_s[0], ~empty_s[1]};

endmodule

// File: tb/tb_apu_ipc_mbox.sv
// Randomised bench for apu_ipc_mbox: a queue-based mailbox model predicts every read,
// a negedge monitor scores read data, outputs are checked after each transfer.
module tb_apu_ipc_mbox;

  localparam int NSOFTIRQ = 2;
  localparam int DEPTH    = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [15:0]         haddr = 16'h0;
  logic [1:0]          htrans = 2'b00;
  logic                hwrite = 1'b0;
  logic [2:0]          hsize = 3'd2;
  logic                hready = 1'b1;
  logic                hmaster = 1'b0;
  logic                hready_resp;
  logic [31:0]         hwdata = 32'h0;
  logic [31:0]         hrdata;
  logic                hresp;
  logic                start_apu;
  logic [NSOFTIRQ-1:0] softirq;
  logic [1:0]          fifo_irq;

  apu_ipc_mbox #(.NSOFTIRQ(NSOFTIRQ), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ahbls_haddr(haddr), .ahbls_htrans(htrans),
    .ahbls_hwrite(hwrite), .ahbls_hsize(hsize), .ahbls_hready(hready),
    .ahbls_hmaster(hmaster), .ahbls_hready_resp(hready_resp), .ahbls_hwdata(hwdata),
    .ahbls_hrdata(hrdata), .ahbls_hresp(hresp), .start_apu(start_apu),
    .riscv_softirq(softirq), .fifo_irq(fifo_irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [31:0]         q_h2a[$];
  logic [31:0]         q_a2h[$];
  logic [NSOFTIRQ-1:0] m_soft = '0;
  logic                m_run = 1'b0;
  logic [1:0]          m_roe = 2'b00;
  logic [1:0]          m_wof = 2'b00;

  // scoreboard: {offset, expected read data}
  logic [34:0]         exp_q[$];
  logic                rd_dp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_op(input logic m, input logic wr, input logic [2:0] off,
                                           input logic [2:0] sz, input logic [31:0] wd);
    int in_lvl;
    int out_lvl;
    logic [31:0] r;
    r       = 32'h0;
    in_lvl  = m ? q_h2a.size() : q_a2h.size();
    out_lvl = m ? q_a2h.size() : q_h2a.size();
    if (wr) begin
      if (sz == 3'd2) begin
        case (off)
          3'd0: m_soft = m_soft | wd[NSOFTIRQ-1:0];
          3'd1: m_soft = m_soft & ~wd[NSOFTIRQ-1:0];
          3'd2: begin
            if (out_lvl == DEPTH) m_wof[m] = 1'b1;
            else if (m) q_a2h.push_back(wd);
            else q_h2a.push_back(wd);
          end
          3'd4: begin
            if (wd[18]) m_roe[m] = 1'b0;
            if (wd[19]) m_wof[m] = 1'b0;
          end
          3'd5: if (!m) m_run = wd[0];
          default: ;
        endcase
      end
    end else begin
      case (off)
        3'd0, 3'd1: r = 32'(m_soft);
        3'd3: begin
          if (in_lvl == 0) m_roe[m] = 1'b1;
          else if (m) r = q_h2a.pop_front();
          else r = q_a2h.pop_front();
        end
        3'd4: r = {12'h0, m_wof[m], m_roe[m], out_lvl < DEPTH, in_lvl != 0, 7'h0, 9'(in_lvl)};
        3'd5: r = {31'h0, m_run};
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  // one transfer: address phase, data phase, then output check against the model
  task automatic xfer(input logic m, input logic wr, input logic [2:0] off,
                      input logic [31:0] wd, input logic [2:0] sz);
    logic [31:0] e;
    @(posedge clk); #1;
    htrans = 2'b10; haddr = {11'h0, off, 2'b00}; hwrite = wr; hsize = sz; hmaster = m;
    @(posedge clk); #1;
    htrans = 2'b00; hwdata = wd;
    e = model_op(m, wr, off, sz, wd);
    if (!wr) begin
      exp_q.push_back({off, e});
      rd_dp = 1'b1;
    end
    @(posedge clk); #1;
    chk("softirq", 32'(softirq), 32'(m_soft));
    chk("start_apu", 32'(start_apu), 32'(m_run));
    chk("fifo_irq", 32'(fifo_irq), {30'h0, q_h2a.size() != 0, q_a2h.size() != 0});
  endtask

  // monitor: score read data in the middle of each read data phase
  always @(negedge clk) begin
    if (rd_dp) begin
      logic [34:0] ent;
      rd_dp = 1'b0;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        ent = exp_q.pop_front();
        chk($sformatf("hrdata off=%0d", ent[34:32]), hrdata, ent[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] off;
    logic       wr;
    logic [2:0] sz;
    logic [31:0] wd;
    #12;
    chk("rst hrdata", hrdata, 32'h0);
    chk("rst hready_resp", 32'(hready_resp), 32'd1);
    chk("rst hresp", 32'(hresp), 32'd0);
    chk("rst outs", {27'h0, start_apu, softirq, fifo_irq}, 32'h0);
    #11 rst_n = 1'b1;

    // soft IRQ set/clear
    xfer(1'b0, 1'b1, 3'd0, 32'h3, 3'd2);
    xfer(1'b0, 1'b0, 3'd0, 32'h0, 3'd2);
    xfer(1'b0, 1'b1, 3'd1, 32'h1, 3'd2);
    xfer(1'b1, 1'b0, 3'd1, 32'h0, 3'd2);
    // host -> APU mailbox
    xfer(1'b0, 1'b1, 3'd2, 32'hA5A5_0001, 3'd2);
    xfer(1'b0, 1'b1, 3'd2, 32'hA5A5_0002, 3'd2);
    xfer(1'b1, 1'b0, 3'd4, 32'h0, 3'd2);
    xfer(1'b1, 1'b0, 3'd3, 32'h0, 3'd2);
    xfer(1'b1, 1'b0, 3'd3, 32'h0, 3'd2);
    // overflow and WOF clear
    for (int i = 0; i <= DEPTH; i++) xfer(1'b0, 1'b1, 3'd2, 32'h1000 + i, 3'd2);
    xfer(1'b0, 1'b0, 3'd4, 32'h0, 3'd2);
    xfer(1'b1, 1'b0, 3'd4, 32'h0, 3'd2);
    xfer(1'b0, 1'b1, 3'd4, 32'h0008_0000, 3'd2);
    xfer(1'b0, 1'b0, 3'd4, 32'h0, 3'd2);
    for (int i = 0; i < DEPTH; i++) xfer(1'b1, 1'b0, 3'd3, 32'h0, 3'd2);
    // empty read sets ROE, then pointers still line up
    xfer(1'b1, 1'b0, 3'd3, 32'h0, 3'd2);
    xfer(1'b1, 1'b0, 3'd4, 32'h0, 3'd2);
    xfer(1'b0, 1'b1, 3'd2, 32'hCAFE_0042, 3'd2);
    xfer(1'b1, 1'b0, 3'd3, 32'h0, 3'd2);
    // run control ownership, ignored narrow write
    xfer(1'b1, 1'b1, 3'd5, 32'h1, 3'd2);
    xfer(1'b0, 1'b1, 3'd5, 32'h1, 3'd0);
    xfer(1'b0, 1'b1, 3'd5, 32'h1, 3'd2);
    xfer(1'b1, 1'b0, 3'd5, 32'h0, 3'd2);

    // randomised traffic, biased towards the FIFO registers
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    begin off = 3'd2; wr = ($urandom_range(0, 7) != 0); end
        2, 3:    begin off = 3'd3; wr = ($urandom_range(0, 7) == 0); end
        4:       begin off = 3'd4; wr = ($urandom_range(0, 3) == 0); end
        5:       begin off = 3'd0; wr = $urandom_range(0, 1) == 1; end
        6:       begin off = 3'd1; wr = $urandom_range(0, 1) == 1; end
        7:       begin off = 3'd5; wr = $urandom_range(0, 1) == 1; end
        8:       begin off = 3'd6; wr = $urandom_range(0, 1) == 1; end
        default: begin off = 3'd7; wr = $urandom_range(0, 1) == 1; end
      endcase
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      wd = $urandom();
      xfer(1'($urandom_range(0, 1)), wr, off, wd, sz);
    end

    // async reset in the middle of a host pop with three words queued
    xfer(1'b0, 1'b1, 3'd0, 32'h3, 3'd2);
    xfer(1'b0, 1'b1, 3'd5, 32'h1, 3'd2);
    while (q_a2h.size() > 3) xfer(1'b0, 1'b0, 3'd3, 32'h0, 3'd2);
    while (q_a2h.size() < 3) xfer(1'b1, 1'b1, 3'd2, $urandom(), 3'd2);
    @(posedge clk); #1;
    htrans = 2'b10; haddr = 16'h000C; hwrite = 1'b0; hsize = 3'd2; hmaster = 1'b0;
    @(posedge clk); #1;
    htrans = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst hrdata", hrdata, 32'h0);
    chk("midrst outs", {27'h0, start_apu, softirq, fifo_irq}, 32'h0);
    chk("midrst hready_resp", 32'(hready_resp), 32'd1);
    q_h2a.delete(); q_a2h.delete();
    m_soft = '0; m_run = 1'b0; m_roe = 2'b00; m_wof = 2'b00;
    #10 rst_n = 1'b1;
    xfer(1'b0, 1'b0, 3'd4, 32'h0, 3'd2);
    xfer(1'b1, 1'b0, 3'd4, 32'h0, 3'd2);
    xfer(1'b0, 1'b0, 3'd3, 32'h0, 3'd2);
    xfer(1'b1, 1'b1, 3'd2, 32'h0BAD_F00D, 3'd2);
    xfer(1'b0, 1'b0, 3'd3, 32'h0, 3'd2);

    @(posedge clk); #1;
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
